// File: rtl/fetch_stage.sv
// Pipelined RV32I instruction fetch: PC register, synchronous imem addressing and IF/ID register.
// Optional saturating FetchCount/FlushCount performance counters when FETCH_PERF_EN is defined.
module fetch_stage #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StallF,
    input  logic                  FlushD,
    input  logic [1:0]            PCSrcE,
    input  logic [ADDR_WIDTH-1:0] PCTargetE,
    input  logic [ADDR_WIDTH-1:0] ALUResultE,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [ADDR_WIDTH-1:0] PCD,
    output logic [ADDR_WIDTH-1:0] PCPlus4D,
    output logic                  ValidD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           FetchCount,
    output logic [31:0]           FlushCount
`endif
);

    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_e;

    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);
    localparam logic [ADDR_WIDTH-1:0] PC_INC    = ADDR_WIDTH'(32'd4);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pcf_q, pcf_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]   pcd_q, pcd_d;
    logic [ADDR_WIDTH-1:0]   pc4_q, pc4_d;
    logic                    valid_q, valid_d;
    logic                    redirect_s;
    logic [ADDR_WIDTH-1:0]   target_s;
    logic [ADDR_WIDTH-1:0]   pc_plus4_s;
    logic [ADDR_WIDTH-1:0]   next_pc_s;

    // Redirect decode; code 11 is deliberately treated like sequential fetch
    always_comb begin
        redirect_s = 1'b0;
        target_s   = PCTargetE;
        case (PCSrcE)
            2'b01: begin
                redirect_s = 1'b1;
                target_s   = PCTargetE;
            end
            2'b10: begin
                redirect_s = 1'b1;
                target_s   = {ALUResultE[ADDR_WIDTH-1:1], 1'b0};
            end
            default: begin
                redirect_s = 1'b0;
                target_s   = PCTargetE;
            end
        endcase
    end

    // Next-state logic for the boot FSM, PC and IF/ID register
    always_comb begin
        state_d    = state_q;
        next_pc_s  = RESET_PC;
        instr_d    = instr_q;
        pcd_d      = pcd_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        pc_plus4_s = pcf_q + PC_INC;
        case (state_q)
            RUN: begin
                state_d = RUN;
                if (redirect_s) begin
                    next_pc_s = target_s;
                end else if (StallF) begin
                    next_pc_s = pcf_q;
                end else begin
                    next_pc_s = pc_plus4_s;
                end
                if (FlushD) begin
                    instr_d = NOP_INSTR;
                    pcd_d   = ADDR_ZERO;
                    pc4_d   = ADDR_ZERO;
                    valid_d = 1'b0;
                end else if (StallF) begin
                    instr_d = instr_q;
                    pcd_d   = pcd_q;
                    pc4_d   = pc4_q;
                    valid_d = valid_q;
                end else begin
                    instr_d = imem_rdata;
                    pcd_d   = pcf_q;
                    pc4_d   = pc_plus4_s;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d   = RUN;
                next_pc_s = RESET_PC;
                instr_d   = NOP_INSTR;
                pcd_d     = ADDR_ZERO;
                pc4_d     = ADDR_ZERO;
                valid_d   = 1'b0;
            end
        endcase
        pcf_d = next_pc_s;
    end

    // The memory is addressed with the PC that will be current next cycle
    assign imem_addr = next_pc_s;

    // State, PC and IF/ID registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
            pcf_q   <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcd_q   <= ADDR_ZERO;
            pc4_q   <= ADDR_ZERO;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pcf_q   <= pcf_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pc4_q;
    assign ValidD   = valid_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((state_q == RUN) && !FlushD && !StallF && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end else begin
            fetch_cnt_d = fetch_cnt_q;
        end
        if ((state_q == RUN) && FlushD && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign FetchCount = fetch_cnt_q;
    assign FlushCount = flush_cnt_q;
`endif

endmodule
